// File: rtl/conv_window_fetch_pkg.sv
// Shared constants for the convolution window fetcher: frame-buffer and pixel widths,
// window size, default resolution and the shortest legal PRESENT hold.
// Pure declarations; no latency or backpressure of its own.
package conv_window_fetch_pkg;

  // Frame-buffer address width; wide enough for 160x120 = 19200 words.
  localparam int AWIDTH_FBUFF = 15;
  // Pixel width: R[11:8], G[7:4], B[3:0].
  localparam int DWIDTH_DAT = 12;
  // Window elements, fixed 3x3.
  localparam int DWSS = 9;

  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;

  // The ALU needs four cycles of stable address to fire its write once.
  localparam int HOLD_MIN = 4;

  // Row (0..2) of a window slot; slots are row-major, slot 4 is the centre.
  function automatic logic [1:0] win_row(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: win_row = 2'd0;
      4'd3, 4'd4, 4'd5: win_row = 2'd1;
      default:          win_row = 2'd2;
    endcase
  endfunction

  // Column (0..2) of a window slot.
  function automatic logic [1:0] win_col(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: win_col = 2'd0;
      4'd1, 4'd4, 4'd7: win_col = 2'd1;
      default:          win_col = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/conv_window_fetch_nbr_addr.sv
// Neighbour address: clamps (x+dx, y+dy) to the frame and forms y*H_RES+x.
// Purely combinational, zero latency.
// No handshake; the caller decides when the address is used.
module conv_nbr_addr
  import conv_window_fetch_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int AW    = AWIDTH_FBUFF,
  parameter int XW    = $clog2(H_RES),
  parameter int YW    = $clog2(V_RES)
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [3:0]    k,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] H_RES_A = AW'(H_RES);
  // Two extra bits: one for the sign of x-1, one so x+1 == H_RES cannot wrap.
  localparam logic signed [XW+1:0] X_MAX_S = (XW+2)'(H_RES - 1);
  localparam logic signed [YW+1:0] Y_MAX_S = (YW+2)'(V_RES - 1);
  localparam logic signed [XW+1:0] X_ONE_S = (XW+2)'(1);
  localparam logic signed [YW+1:0] Y_ONE_S = (YW+2)'(1);

  logic [1:0]             row;
  logic [1:0]             col;
  logic signed [XW+1:0]   xs;
  logic signed [YW+1:0]   ys;
  logic [XW-1:0]          cx;
  logic [YW-1:0]          cy;

  // Offset the centre coordinate, replicate edges by saturating, then linearise.
  always_comb begin
    row = win_row(k);
    col = win_col(k);
    xs  = $signed({2'b00, x}) + $signed({{XW{1'b0}}, col}) - X_ONE_S;
    ys  = $signed({2'b00, y}) + $signed({{YW{1'b0}}, row}) - Y_ONE_S;

    if (xs < 0)              cx = '0;
    else if (xs > X_MAX_S)   cx = X_MAX_S[XW-1:0];
    else                     cx = xs[XW-1:0];

    if (ys < 0)              cy = '0;
    else if (ys > Y_MAX_S)   cy = Y_MAX_S[YW-1:0];
    else                     cy = ys[YW-1:0];

    addr = AW'(cy) * H_RES_A + AW'(cx);
  end

endmodule

// File: rtl/conv_window_fetch.sv
// Raster-order 3x3 window fetcher feeding the convolution ALU.
// 9 reads + 1 drain + HOLD present cycles per pixel; read data lands 1 cycle after each read.
// No backpressure: source reads are assumed always granted; the ALU is paced by the HOLD window.
module conv_window_fetch
  import conv_window_fetch_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int AW    = AWIDTH_FBUFF,
  parameter int DW    = DWIDTH_DAT,
  parameter int NWIN  = DWSS,
  parameter int HOLD  = HOLD_MIN   // must be >= HOLD_MIN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      rd_addr_src,
  output logic               rd_en_src,
  input  logic [DW-1:0]      rd_data_src,
  output logic [NWIN*DW-1:0] din,
  output logic [AW-1:0]      raddr_alu,
  output logic               ren_alu
);

  localparam int XW  = $clog2(H_RES);
  localparam int YW  = $clog2(V_RES);
  localparam int HCW = $clog2(HOLD) + 1;

  localparam logic [XW-1:0]  X_MAX    = XW'(H_RES - 1);
  localparam logic [YW-1:0]  Y_MAX    = YW'(V_RES - 1);
  localparam logic [3:0]     K_LAST   = 4'(NWIN - 1);
  localparam logic [HCW-1:0] HOLD_END = HCW'(HOLD - 1);
  localparam logic [AW-1:0]  H_RES_A  = AW'(H_RES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t         state, state_d;
  logic [XW-1:0]  x, x_d;
  logic [YW-1:0]  y, y_d;
  logic [3:0]     k;
  logic [HCW-1:0] hold_cnt;
  logic           rd_vld_q;
  logic [3:0]     rd_slot_q;
  logic [AW-1:0]  nbr_addr;
  logic           last_px;
  logic           hold_end;
  logic           fetch_entry;

  conv_nbr_addr #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .AW    (AW),
    .XW    (XW),
    .YW    (YW)
  ) u_nbr_addr (
    .x    (x),
    .y    (y),
    .k    (k),
    .addr (nbr_addr)
  );

  assign last_px     = (x == X_MAX) && (y == Y_MAX);
  assign hold_end    = (hold_cnt == HOLD_END);
  assign fetch_entry = (state_d == S_FETCH) && (state != S_FETCH);

  // Next state, next pixel coordinates and Moore outputs.
  always_comb begin
    state_d     = state;
    x_d         = x;
    y_d         = y;
    busy        = 1'b0;
    done        = 1'b0;
    rd_en_src   = 1'b0;
    rd_addr_src = '0;
    ren_alu     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_FETCH: begin
        busy        = 1'b1;
        rd_en_src   = 1'b1;
        rd_addr_src = nbr_addr;
        if (k == K_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        busy    = 1'b1;
        ren_alu = 1'b1;
        if (hold_end) begin
          if (last_px) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            if (x == X_MAX) begin
              x_d = '0;
              y_d = y + 1'b1;
            end else begin
              x_d = x + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, coordinates and per-phase counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      x        <= '0;
      y        <= '0;
      k        <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      x        <= x_d;
      y        <= y_d;
      k        <= (state == S_FETCH) ? k + 1'b1 : 4'd0;
      hold_cnt <= (state == S_PRESENT) ? hold_cnt + 1'b1 : '0;
    end
  end

  // Pixel address for the ALU changes only as a new fetch begins, so it is
  // stable for the whole PRESENT window.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_alu <= '0;
    end else if (fetch_entry) begin
      raddr_alu <= AW'(y_d) * H_RES_A + AW'(x_d);
    end
  end

  // Remember which slot each read targets; data arrives one cycle later.
  // Clearing on reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_slot_q <= '0;
    end else begin
      rd_vld_q  <= rd_en_src;
      rd_slot_q <= k;
    end
  end

  // Window assembly; nothing is written during PRESENT, so din stays frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      din <= '0;
    end else if (rd_vld_q) begin
      for (int i = 0; i < NWIN; i++) begin
        if (rd_slot_q == 4'(i)) din[DW*i +: DW] <= rd_data_src;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_fetch.sv
module tb_conv_window_fetch;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 15;
  localparam int DW = 12;
  localparam int NW = 9;
  localparam int NPIX = H * V;
  localparam int LAST_PRESENT = 14 * NPIX;   // 168
  localparam int DONE_CYC     = LAST_PRESENT + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               busy;
  logic               done;
  logic [AW-1:0]      rd_addr_src;
  logic               rd_en_src;
  logic [DW-1:0]      rd_data_src;
  logic [NW*DW-1:0]   din;
  logic [AW-1:0]      raddr_alu;
  logic               ren_alu;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard queues, filled when a frame is started.
  int               rdq[$];
  int               aq[$];
  logic [NW*DW-1:0] wq[$];

  // ALU address-match model state.
  int            alu_cnt = 0;
  logic          alu_prev_ren = 1'b0;
  logic [AW-1:0] alu_prev_addr = '0;
  int            wen_cnt = 0;

  conv_window_fetch #(
    .H_RES (H),
    .V_RES (V),
    .AW    (AW),
    .DW    (DW),
    .NWIN  (NW),
    .HOLD  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rd_addr_src (rd_addr_src),
    .rd_en_src   (rd_en_src),
    .rd_data_src (rd_data_src),
    .din         (din),
    .raddr_alu   (raddr_alu),
    .ren_alu     (ren_alu)
  );

  always #5 clk = ~clk;

  // Source frame buffer: word a holds 12'h100 + a, one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en_src) rd_data_src <= 12'h100 + 12'(rd_addr_src);
  end

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int nbr(input int x, input int y, input int k);
    int yy, xx;
    yy = clampi(y + k / 3 - 1, V - 1);
    xx = clampi(x + k % 3 - 1, H - 1);
    return yy * H + xx;
  endfunction

  task automatic push_expected();
    logic [NW*DW-1:0] w;
    for (int p = 0; p < NPIX; p++) begin
      w = '0;
      for (int k = 0; k < NW; k++) begin
        rdq.push_back(nbr(p % H, p / H, k));
        w[DW*k +: DW] = 12'h100 + 12'(nbr(p % H, p / H, k));
      end
      aq.push_back(p);
      wq.push_back(w);
    end
    wen_cnt = 0;
  endtask

  // Monitor: checks every source read and every ALU write against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      rdq.delete();
      aq.delete();
      wq.delete();
      alu_cnt      = 0;
      alu_prev_ren = 1'b0;
    end else begin
      if (rd_en_src) begin
        n_cmp++;
        if (rdq.size() == 0) begin
          n_fail++;
          $display("FAIL rd_addr_extra: read addr %0d, no read expected", rd_addr_src);
        end else begin
          int e;
          e = rdq.pop_front();
          if (rd_addr_src !== AW'(e)) begin
            n_fail++;
            $display("FAIL rd_addr: got %0d, expected %0d", rd_addr_src, e);
          end
        end
        n_cmp++;
        if (ren_alu !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_during_present: ren_alu=%b with rd_en_src=1, expected 0", ren_alu);
        end
      end
      if (ren_alu) begin
        if (alu_prev_ren && raddr_alu == alu_prev_addr) alu_cnt++;
        else alu_cnt = 1;
      end else begin
        alu_cnt = 0;
      end
      alu_prev_ren  = ren_alu;
      alu_prev_addr = raddr_alu;
      if (ren_alu && alu_cnt == 4) begin
        wen_cnt++;
        n_cmp++;
        if (aq.size() == 0) begin
          n_fail++;
          $display("FAIL wen_extra: wen at addr %0d, none expected", raddr_alu);
        end else begin
          int ea;
          logic [NW*DW-1:0] ew;
          ea = aq.pop_front();
          ew = wq.pop_front();
          if (raddr_alu !== AW'(ea)) begin
            n_fail++;
            $display("FAIL wen_addr: got %0d, expected %0d", raddr_alu, ea);
          end
          n_cmp++;
          if (din !== ew) begin
            n_fail++;
            $display("FAIL window: addr %0d got %h, expected %h", raddr_alu, din, ew);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({busy, done, ren_alu, rd_en_src} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl: busy/done/ren/rd_en=%b, expected 0000", {busy, done, ren_alu, rd_en_src});
    end
    n_cmp++;
    if (rd_addr_src !== '0 || raddr_alu !== '0 || din !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rd_addr=%0d raddr=%0d din=%h, expected all 0", rd_addr_src, raddr_alu, din);
    end
  endtask

  // Full frame with cycle-exact timing; cycle 0 is the start cycle.
  task automatic test_full_frame();
    int r;
    bit ren_e, rd_e, busy_e, done_e;
    @(posedge clk);
    #1 start = 1'b1;
    push_expected();
    for (int n = 1; n <= DONE_CYC + 3; n++) begin
      @(posedge clk);
      #1 start = 1'b0;
      r      = (n - 1) % 14;
      ren_e  = (n <= LAST_PRESENT) && (r >= 10);
      rd_e   = (n <= LAST_PRESENT) && (r < 9);
      busy_e = (n >= 1) && (n <= LAST_PRESENT);
      done_e = (n == DONE_CYC);
      n_cmp++;
      if ({ren_alu, rd_en_src, busy, done} !== {ren_e, rd_e, busy_e, done_e}) begin
        n_fail++;
        $display("FAIL timing: cycle %0d ren/rd/busy/done=%b, expected %b", n,
                 {ren_alu, rd_en_src, busy, done}, {ren_e, rd_e, busy_e, done_e});
      end
      if (n == 11) begin
        n_cmp++;
        if (din[11:0] !== 12'h100 || din[107:96] !== 12'h105) begin
          n_fail++;
          $display("FAIL px0_slots: slot0=%h slot8=%h, expected 100 105", din[11:0], din[107:96]);
        end
      end
      if (n >= 11 && n <= 14) begin
        n_cmp++;
        if (raddr_alu !== '0) begin
          n_fail++;
          $display("FAIL px0_raddr: cycle %0d got %0d, expected 0", n, raddr_alu);
        end
      end
    end
    n_cmp++;
    if (wen_cnt !== NPIX || rdq.size() != 0 || aq.size() != 0) begin
      n_fail++;
      $display("FAIL frame_count: wen=%0d left_rd=%0d left_wen=%0d, expected %0d 0 0",
               wen_cnt, rdq.size(), aq.size(), NPIX);
    end
  endtask

  task automatic test_start_while_busy();
    int done_at;
    done_at = -1;
    @(posedge clk);
    #1 start = 1'b1;
    push_expected();
    for (int n = 1; n <= DONE_CYC + 20; n++) begin
      @(posedge clk);
      #1 start = (n == 50);
      if (done && done_at < 0) done_at = n;
    end
    start = 1'b0;
    n_cmp++;
    if (done_at != DONE_CYC) begin
      n_fail++;
      $display("FAIL busy_start_done: done at cycle %0d, expected %0d", done_at, DONE_CYC);
    end
    n_cmp++;
    if (wen_cnt !== NPIX || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_frame: wen=%0d busy=%b, expected %0d 0", wen_cnt, busy, NPIX);
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk);
    #1 start = 1'b1;
    push_expected();
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({ren_alu, rd_en_src, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_ctl: ren/rd/busy/done=%b, expected 0000", {ren_alu, rd_en_src, busy, done});
    end
    n_cmp++;
    if (din !== '0 || raddr_alu !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_data: din=%h raddr=%0d, expected 0 0", din, raddr_alu);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: busy=%b, expected 0", busy);
    end
    test_full_frame();
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    rd_data_src = '0;
    test_reset();
    test_full_frame();
    repeat (5) @(posedge clk);
    test_start_while_busy();
    repeat (5) @(posedge clk);
    test_mid_reset();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
